// File: rtl/seg_scan_decoder.sv
// Loop-back readback monitor for a multiplexed seven-segment display.
// Samples the scanned anode/cathode buses, waits for each digit to settle, decodes glyphs and publishes whole frames.
module seg_scan_decoder #(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_DIGITS-1:0]   disp_an_i,
  input  logic [7:0]            disp_seg_i,
  output logic [4*N_DIGITS-1:0] value_o,
  output logic [N_DIGITS-1:0]   dp_o,
  output logic [N_DIGITS-1:0]   digit_err_o,
  output logic                  frame_valid_o,
  output logic                  anode_err_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned LOW_W = $clog2(N_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUBLISH
  } state_t;

  state_t state_q, state_d;

  logic [N_DIGITS-1:0]   an_meta, an_sync, an_prev;
  logic [7:0]            seg_meta, seg_sync, seg_prev;
  logic [CNT_W-1:0]      cnt_q;
  logic                  settle_hit;

  logic [LOW_W-1:0]      low_cnt;
  logic [IDX_W-1:0]      sel_idx;
  logic                  is_dwell, is_multi, capture;
  logic [3:0]            dec_nib;
  logic                  dec_err;

  logic [4*N_DIGITS-1:0] shadow_val;
  logic [N_DIGITS-1:0]   shadow_dp, shadow_err;
  logic [N_DIGITS-1:0]   captured_q, captured_d;
  logic                  publish_go;

  logic [4*N_DIGITS-1:0] value_q;
  logic [N_DIGITS-1:0]   dp_q, err_q;
  logic                  anode_err_q;

  // Active-low glyph (g..a) back to a hex nibble; anything else is an error.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = {1'b0, 4'h0};
      7'h79:   r = {1'b0, 4'h1};
      7'h24:   r = {1'b0, 4'h2};
      7'h30:   r = {1'b0, 4'h3};
      7'h19:   r = {1'b0, 4'h4};
      7'h12:   r = {1'b0, 4'h5};
      7'h02:   r = {1'b0, 4'h6};
      7'h78:   r = {1'b0, 4'h7};
      7'h00:   r = {1'b0, 4'h8};
      7'h10:   r = {1'b0, 4'h9};
      7'h08:   r = {1'b0, 4'hA};
      7'h03:   r = {1'b0, 4'hB};
      7'h46:   r = {1'b0, 4'hC};
      7'h21:   r = {1'b0, 4'hD};
      7'h06:   r = {1'b0, 4'hE};
      7'h0E:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_meta  <= '1;
      an_sync  <= '1;
      an_prev  <= '1;
      seg_meta <= '1;
      seg_sync <= '1;
      seg_prev <= '1;
      cnt_q    <= '0;
    end else begin
      an_meta  <= disp_an_i;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
      seg_meta <= disp_seg_i;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
      if ({an_sync, seg_sync} != {an_prev, seg_prev}) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(SETTLE_CYCLES)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // cnt_q describes how long an_prev/seg_prev have been stable, so classify on those.
  assign settle_hit = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  always_comb begin
    low_cnt = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!an_prev[i]) begin
        low_cnt = low_cnt + 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign is_dwell = (low_cnt == LOW_W'(1));
  assign is_multi = (low_cnt > LOW_W'(1));
  assign capture  = settle_hit && is_dwell;
  assign {dec_err, dec_nib} = decode_glyph(seg_prev[6:0]);

  assign publish_go = (state_q == COLLECT) && (&captured_q);

  always_comb begin
    captured_d = publish_go ? '0 : captured_q;
    if (capture) begin
      captured_d[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      shadow_err <= '0;
      captured_q <= '0;
    end else begin
      captured_q <= captured_d;
      if (capture) begin
        shadow_val[{sel_idx, 2'b00} +: 4] <= dec_nib;
        shadow_dp[sel_idx]                <= ~seg_prev[7];
        shadow_err[sel_idx]               <= dec_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|captured_q) state_d = COLLECT;
      COLLECT: if (&captured_q) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q     <= '0;
      dp_q        <= '0;
      err_q       <= '0;
      anode_err_q <= 1'b0;
    end else begin
      anode_err_q <= settle_hit && is_multi;
      if (publish_go) begin
        value_q <= shadow_val;
        dp_q    <= shadow_dp;
        err_q   <= shadow_err;
      end
    end
  end

  assign value_o       = value_q;
  assign dp_o          = dp_q;
  assign digit_err_o   = err_q;
  assign frame_valid_o = (state_q == PUBLISH);
  assign anode_err_o   = anode_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-frame scans plus hand-written corner sequences.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an, seg;
  logic [31:0] value;
  logic [7:0]  dp, derr;
  logic        frame_valid, anode_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.N_DIGITS(8), .SETTLE_CYCLES(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .disp_an_i    (an),
    .disp_seg_i   (seg),
    .value_o      (value),
    .dp_o         (dp),
    .digit_err_o  (derr),
    .frame_valid_o(frame_valid),
    .anode_err_o  (anode_err)
  );

  typedef struct {
    string       name;
    logic [31:0] shown;
    logic [7:0]  dp_on;
    logic [7:0]  bad;
    logic [31:0] exp_val;
    logic [7:0]  exp_dp;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t        vecs [3];
  logic [6:0]  glyph [16];
  int          checks = 0, errors = 0;
  int          frames = 0, aerrs = 0;
  logic [31:0] lv = '0;
  logic [7:0]  ldp = '0, lerr = '0;

  always @(negedge clk) begin
    if (frame_valid) begin
      frames++;
      lv   = value;
      ldp  = dp;
      lerr = derr;
    end
    if (anode_err) aerrs++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int k, input logic [7:0] s, input int n);
    an  = ~(8'h01 << k);
    seg = s;
    cycles(n);
  endtask

  task automatic blank(input int n);
    an  = '1;
    seg = '1;
    cycles(n);
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic dpon);
    return {~dpon, glyph[nib]};
  endfunction

  initial begin
    int f0, a0, bad_cycles;
    logic [7:0] s;

    glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
    glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
    glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
    glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;

    vecs[0] = '{"scan_12345678", 32'h87654321, 8'h00, 8'h00, 32'h87654321, 8'h00, 8'h00};
    vecs[1] = '{"scan_deadbeef", 32'hDEADBEEF, 8'h08, 8'h20, 32'hDE0DBEEF, 8'h08, 8'h20};
    vecs[2] = '{"scan_9abc0def", 32'h9ABC0DEF, 8'hFF, 8'h81, 32'h0ABC0DE0, 8'hFF, 8'h81};

    // Reset held with random inputs: outputs stay zero, no pulses.
    rst_n = 1'b0;
    an = '1; seg = '1;
    bad_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      an  = 8'($urandom);
      seg = 8'($urandom);
      if (value !== '0 || dp !== '0 || derr !== '0 || frame_valid !== 1'b0 || anode_err !== 1'b0)
        bad_cycles++;
    end
    check("reset_outputs_zero", 32'(bad_cycles), 32'd0);
    check("reset_no_frame", 32'(frames), 32'd0);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      an  = 8'($urandom);
      seg = 8'($urandom);
    end
    blank(30);
    check("post_reset_no_frame", 32'(frames), 32'd0);
    check("post_reset_no_anode_err", 32'(aerrs), 32'd0);

    // Full-frame scans from the table.
    for (int v = 0; v < 3; v++) begin
      f0 = frames;
      for (int k = 0; k < 8; k++) begin
        if (vecs[v].bad[k]) s = {~vecs[v].dp_on[k], 7'h7F};
        else                s = seg_of(vecs[v].shown[4*k +: 4], vecs[v].dp_on[k]);
        show(k, s, 100);
      end
      blank(20);
      check({vecs[v].name, "_frames"}, 32'(frames - f0), 32'd1);
      check({vecs[v].name, "_value"}, lv, vecs[v].exp_val);
      check({vecs[v].name, "_dp"}, 32'(ldp), 32'(vecs[v].exp_dp));
      check({vecs[v].name, "_err"}, 32'(lerr), 32'(vecs[v].exp_err));
    end

    // Glitch: short dwell showing 8 on the last missing digit must not complete the frame.
    f0 = frames;
    for (int k = 1; k < 8; k++) show(k, seg_of(4'(k + 1), 1'b0), 100);
    show(0, seg_of(4'h8, 1'b0), 14);
    check("glitch_no_early_frame", 32'(frames - f0), 32'd0);
    show(0, seg_of(4'h1, 1'b0), 100);
    blank(20);
    check("glitch_frames", 32'(frames - f0), 32'd1);
    check("glitch_value", lv, 32'h87654321);

    // Anode fault: two anodes low held; single error pulse, nothing captured.
    f0 = frames;
    a0 = aerrs;
    an  = 8'hFC;
    seg = seg_of(4'h3, 1'b0);
    cycles(50);
    blank(20);
    check("anode_err_pulses", 32'(aerrs - a0), 32'd1);
    check("anode_no_frame", 32'(frames - f0), 32'd0);
    for (int k = 1; k < 8; k++) show(k, seg_of(4'h0, 1'b0), 100);
    blank(20);
    check("anode_no_capture", 32'(frames - f0), 32'd0);
    show(0, seg_of(4'h0, 1'b0), 100);
    blank(20);
    check("anode_then_frame", 32'(frames - f0), 32'd1);
    check("anode_then_value", lv, 32'h00000000);

    // Reset mid-frame discards partial captures.
    for (int k = 0; k < 5; k++) show(k, seg_of(4'(k + 1), 1'b0), 100);
    blank(5);
    rst_n = 1'b0;
    cycles(5);
    check("midreset_value_cleared", value, 32'h0);
    rst_n = 1'b1;
    blank(20);
    f0 = frames;
    for (int j = 0; j < 8; j++) show((j + 5) % 8, seg_of(4'h0, 1'b0), 100);
    blank(20);
    check("midreset_frames", 32'(frames - f0), 32'd1);
    check("midreset_value", lv, 32'h00000000);
    check("midreset_err", 32'(lerr), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
